map_cell_fetcher: RTL and testbench
===================================

// Module: map_cell_fetcher
// PURPOSE
// Requester side of the grid-map read interface. Accepts (x,y) cell coordinates from a ray/DDA client
// over valid/ready, forms the linear map address, issues a single-cycle read request to the grid map,
// waits for its 2-cycle-latency response, and returns the cell value to the client with status flags.
// Sits between the DDA stepping logic and the grid map RAM wrapper.
// PARAMETERS
// N              24   map edge length in cells; address = y*N + x
// MAP_DATA_WIDTH 5    width of one map cell value
// OOB_VALUE      1    cell value returned for out-of-map coordinates or timeout (treated as wall)
// TIMEOUT        15   max cycles spent in WAIT before giving up
// PORTS
// pixel_clk_in     in   1                  pixel clock, all logic on rising edge
// rst_n_in         in   1                  reset, asynchronous assert, active-low
// cell_valid_in    in   1                  client presents coordinates
// cell_ready_out   out  1                  fetcher can accept coordinates
// cell_x_in        in   $clog2(N)          cell column
// cell_y_in        in   $clog2(N)          cell row
// resp_valid_out   out  1                  response held for client
// resp_ready_in    in   1                  client accepts response
// resp_data_out    out  MAP_DATA_WIDTH     cell value
// resp_oob_out     out  1                  coordinates were outside the map
// resp_timeout_out out  1                  map never answered within TIMEOUT
// map_req_out      out  1                  read request pulse to grid map
// map_addr_out     out  $clog2(N*N)        read address to grid map
// map_valid_in     in   1                  grid map response valid
// map_data_in      in   MAP_DATA_WIDTH     grid map response data
// busy_out         out  1                  high whenever state != IDLE
// BEHAVIOUR
// - Reset (rst_n_in low, any time, async): state=IDLE; map_req_out=0, map_addr_out=0, resp_valid_out=0,
//   resp_data_out=0, resp_oob_out=0, resp_timeout_out=0, busy_out=0; cell_ready_out=1 after release.
// - States: IDLE, ISSUE, WAIT, RESP. cell_ready_out = (state==IDLE), combinational.
// - IDLE: on cell_valid_in&&cell_ready_out at edge T, register x,y. If x>=N or y>=N -> RESP at T+1 with
//   resp_data_out=OOB_VALUE, resp_oob_out=1, no map request issued. Else map_addr_out<=y*N+x
//   (unsigned, computed at $clog2(N*N) bits, no truncation for in-range inputs) -> ISSUE.
// - ISSUE (exactly 1 cycle): map_req_out=1 (registered), map_addr_out stable -> WAIT, timeout counter=0.
// - WAIT: map_req_out=0; map_addr_out held stable until leaving WAIT. On map_valid_in: capture
//   map_data_in into resp_data_out, flags 0 -> RESP. Nominal: request cycle T+1, map_valid_in at T+3,
//   resp_valid_out high from T+4. Counter increments each WAIT cycle; when it reaches TIMEOUT with no
//   map_valid_in -> RESP with resp_data_out=OOB_VALUE, resp_timeout_out=1. Valid arriving on the same
//   cycle the count hits TIMEOUT wins (data taken, timeout=0).
// - RESP: resp_valid_out=1; data/flags held constant until resp_valid_out&&resp_ready_in; then -> IDLE,
//   resp_valid_out=0 next cycle. No new coordinates accepted while in RESP (no skid buffer).
// - map_req_out is always a single-cycle pulse followed by >=2 low cycles, satisfying the grid map's
//   rising-edge request detection; back-to-back fetches are never merged.
// - map_valid_in outside WAIT is ignored (no state change, no capture).
// - Throughput: one fetch per >=5 cycles in-range (IDLE,ISSUE,WAIT x2,RESP), >=2 cycles out-of-range.
// - Flags resp_oob_out and resp_timeout_out are mutually exclusive; both cleared on entry to ISSUE.
// TESTING
// - Reset: hold rst_n_in low mid-clock -> all outputs 0 immediately; after release cell_ready_out=1.
// - In-range: x=3,y=2, model returns 5'd7 two cycles after req -> map_addr_out=51, one req pulse,
//   resp_valid_out at T+4 with data=7, oob=0, timeout=0.
// - Out-of-range: x=24,y=0 -> no map_req_out, resp_valid_out at T+1, data=1, resp_oob_out=1.
// - Backpressure: resp_ready_in low 5 cycles after response -> data/flags stable, cell_ready_out=0,
//   completes on first ready cycle; then x=23,y=23 fetch -> addr 575.
// - Timeout: model never answers -> after 15 WAIT cycles resp data=1, resp_timeout_out=1; stray late
//   map_valid_in ignored.
// - Reset mid-WAIT -> IDLE, no response emitted; subsequent fetch x=0,y=1 -> addr 24, correct data.

Source files
------------

// File: rtl/map_cell_fetcher.sv
// map_cell_fetcher: requester side of the grid-map read port.
// Takes (x,y) from the DDA client, issues one read pulse to the grid map,
// waits for the 2-cycle response (bounded by TIMEOUT) and hands the cell
// value back to the client with out-of-map / timeout flags.
module map_cell_fetcher #(
  parameter int N              = 24,
  parameter int MAP_DATA_WIDTH = 5,
  parameter int OOB_VALUE      = 1,
  parameter int TIMEOUT        = 15
) (
  input  logic                        pixel_clk_in,
  input  logic                        rst_n_in,
  input  logic                        cell_valid_in,
  output logic                        cell_ready_out,
  input  logic [$clog2(N)-1:0]        cell_x_in,
  input  logic [$clog2(N)-1:0]        cell_y_in,
  output logic                        resp_valid_out,
  input  logic                        resp_ready_in,
  output logic [MAP_DATA_WIDTH-1:0]   resp_data_out,
  output logic                        resp_oob_out,
  output logic                        resp_timeout_out,
  output logic                        map_req_out,
  output logic [$clog2(N*N)-1:0]      map_addr_out,
  input  logic                        map_valid_in,
  input  logic [MAP_DATA_WIDTH-1:0]   map_data_in,
  output logic                        busy_out
);

  localparam int XW = $clog2(N);
  localparam int AW = $clog2(N*N);
  // Counter only has to reach TIMEOUT-1: the last WAIT cycle decides.
  localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [CW-1:0]             CNT_LAST = CW'(TIMEOUT - 1);
  localparam logic [MAP_DATA_WIDTH-1:0] OOB_DATA = MAP_DATA_WIDTH'(OOB_VALUE);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_WAIT  = 2'd2,
    S_RESP  = 2'd3
  } state_t;

  state_t                    state_q, state_d;
  logic                      map_req_q, map_req_d;
  logic [AW-1:0]             map_addr_q, map_addr_d;
  logic [MAP_DATA_WIDTH-1:0] resp_data_q, resp_data_d;
  logic                      resp_oob_q, resp_oob_d;
  logic                      resp_timeout_q, resp_timeout_d;
  logic [CW-1:0]             cnt_q, cnt_d;

  // Coordinates are compared one bit wider so a power-of-two N still works.
  function automatic logic coord_in_map(input logic [XW-1:0] x, input logic [XW-1:0] y);
    return ({1'b0, x} < (XW+1)'(N)) && ({1'b0, y} < (XW+1)'(N));
  endfunction

  // Row-major linear address, computed at full address width.
  function automatic logic [AW-1:0] linear_addr(input logic [XW-1:0] x, input logic [XW-1:0] y);
    return AW'(y) * AW'(N) + AW'(x);
  endfunction

  // Next-state and datapath update for the fetch sequence.
  always_comb begin
    state_d        = state_q;
    map_req_d      = 1'b0;
    map_addr_d     = map_addr_q;
    resp_data_d    = resp_data_q;
    resp_oob_d     = resp_oob_q;
    resp_timeout_d = resp_timeout_q;
    cnt_d          = cnt_q;
    unique case (state_q)
      S_IDLE: begin
        if (cell_valid_in) begin
          if (coord_in_map(cell_x_in, cell_y_in)) begin
            map_addr_d     = linear_addr(cell_x_in, cell_y_in);
            map_req_d      = 1'b1;
            resp_oob_d     = 1'b0;
            resp_timeout_d = 1'b0;
            state_d        = S_ISSUE;
          end else begin
            // Outside the map reads as wall without touching the RAM.
            resp_data_d    = OOB_DATA;
            resp_oob_d     = 1'b1;
            resp_timeout_d = 1'b0;
            state_d        = S_RESP;
          end
        end
      end
      S_ISSUE: begin
        cnt_d   = '0;
        state_d = S_WAIT;
      end
      S_WAIT: begin
        // A response on the final WAIT cycle still beats the timeout.
        if (map_valid_in) begin
          resp_data_d    = map_data_in;
          resp_oob_d     = 1'b0;
          resp_timeout_d = 1'b0;
          state_d        = S_RESP;
        end else if (cnt_q == CNT_LAST) begin
          resp_data_d    = OOB_DATA;
          resp_timeout_d = 1'b1;
          state_d        = S_RESP;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      S_RESP: begin
        if (resp_ready_in) begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State and output registers, asynchronously cleared.
  always_ff @(posedge pixel_clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      state_q        <= S_IDLE;
      map_req_q      <= 1'b0;
      map_addr_q     <= '0;
      resp_data_q    <= '0;
      resp_oob_q     <= 1'b0;
      resp_timeout_q <= 1'b0;
      cnt_q          <= '0;
    end else begin
      state_q        <= state_d;
      map_req_q      <= map_req_d;
      map_addr_q     <= map_addr_d;
      resp_data_q    <= resp_data_d;
      resp_oob_q     <= resp_oob_d;
      resp_timeout_q <= resp_timeout_d;
      cnt_q          <= cnt_d;
    end
  end

  // Ready is held low while reset is asserted so every output reads 0 then.
  assign cell_ready_out   = (state_q == S_IDLE) && rst_n_in;
  assign busy_out         = (state_q != S_IDLE);
  assign resp_valid_out   = (state_q == S_RESP);
  assign resp_data_out    = resp_data_q;
  assign resp_oob_out     = resp_oob_q;
  assign resp_timeout_out = resp_timeout_q;
  assign map_req_out      = map_req_q;
  assign map_addr_out     = map_addr_q;

endmodule

// File: tb/tb_map_cell_fetcher.sv
// Bench for map_cell_fetcher: a grid-map responder with programmable latency,
// a request-pulse monitor, and per-scenario tasks checked against a
// coordinate/latency reference model.
module tb_map_cell_fetcher;

  localparam int N    = 24;
  localparam int DW   = 5;
  localparam int OOBV = 1;
  localparam int TMO  = 15;
  localparam int XW   = $clog2(N);
  localparam int AW   = $clog2(N*N);

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst_n;
  logic          cell_valid;
  logic          cell_ready_out;
  logic [XW-1:0] cell_x, cell_y;
  logic          resp_valid_out;
  logic          resp_ready;
  logic [DW-1:0] resp_data_out;
  logic          resp_oob_out, resp_timeout_out;
  logic          map_req_out;
  logic [AW-1:0] map_addr_out;
  logic          map_valid;
  logic [DW-1:0] map_data;
  logic          busy_out;

  logic          rsp_valid, stray_valid;
  logic [DW-1:0] rsp_data, stray_data;
  assign map_valid = rsp_valid | stray_valid;
  assign map_data  = stray_valid ? stray_data : rsp_data;

  map_cell_fetcher #(.N(N), .MAP_DATA_WIDTH(DW), .OOB_VALUE(OOBV), .TIMEOUT(TMO)) dut (
    .pixel_clk_in    (clk),
    .rst_n_in        (rst_n),
    .cell_valid_in   (cell_valid),
    .cell_ready_out  (cell_ready_out),
    .cell_x_in       (cell_x),
    .cell_y_in       (cell_y),
    .resp_valid_out  (resp_valid_out),
    .resp_ready_in   (resp_ready),
    .resp_data_out   (resp_data_out),
    .resp_oob_out    (resp_oob_out),
    .resp_timeout_out(resp_timeout_out),
    .map_req_out     (map_req_out),
    .map_addr_out    (map_addr_out),
    .map_valid_in    (map_valid),
    .map_data_in     (map_data),
    .busy_out        (busy_out)
  );

  int            checks = 0;
  int            errors = 0;
  logic [DW-1:0] mem [N*N];
  int            map_lat = 2;
  int            req_cnt = 0;
  int            gap_viol = 0;
  bit            rsp_busy = 1'b0;
  logic [AW-1:0] last_req_addr = '0;
  bit [1:0]      req_hist = 2'b00;

  // Request monitor: counts pulses and flags any pulse with <2 low cycles before it.
  initial forever begin
    @(negedge clk);
    if (map_req_out === 1'b1) begin
      req_cnt++;
      if (req_hist != 2'b00) gap_viol++;
    end
    req_hist = {req_hist[0], map_req_out === 1'b1};
  end

  // Grid map model: answers mem[addr] map_lat cycles after the request cycle (0 = never).
  initial begin
    rsp_valid = 1'b0;
    rsp_data  = '0;
    forever begin
      @(negedge clk);
      if (map_req_out === 1'b1) begin
        last_req_addr = map_addr_out;
        if (map_lat > 0) begin
          rsp_busy = 1'b1;
          repeat (map_lat) @(negedge clk);
          rsp_valid = 1'b1;
          rsp_data  = mem[last_req_addr];
          @(negedge clk);
          rsp_valid = 1'b0;
          rsp_busy  = 1'b0;
        end
      end
    end
  end

  // Drives one fetch and reports what was observed; lat counts cycles after acceptance.
  task automatic fetch(input logic [XW-1:0] x, input logic [XW-1:0] y, input int hold,
                       input bit stray, output int lat, output logic [DW-1:0] d,
                       output logic oob, output logic to, output logic [AW-1:0] a,
                       output int reqs, output bit stable, output bit done_ok);
    int k;
    int r0;
    lat = -1; d = '0; oob = 1'b0; to = 1'b0; a = '0; reqs = 0; stable = 1'b1; done_ok = 1'b0;
    k = 0;
    while ((!cell_ready_out || rsp_busy) && k < 60) begin
      @(negedge clk);
      k++;
    end
    r0 = req_cnt;
    cell_valid = 1'b1;
    cell_x = x;
    cell_y = y;
    @(negedge clk);
    cell_valid = 1'b0;
    k = 1;
    while (!resp_valid_out && k < 40) begin
      @(negedge clk);
      k++;
    end
    reqs = req_cnt - r0;
    if (resp_valid_out) begin
      lat = k;
      d   = resp_data_out;
      oob = resp_oob_out;
      to  = resp_timeout_out;
      a   = last_req_addr;
      for (int i = 0; i < hold; i++) begin
        stray_valid = stray;
        stray_data  = ~d;
        @(negedge clk);
        if (!(resp_valid_out && !cell_ready_out && busy_out && resp_data_out == d &&
              resp_oob_out == oob && resp_timeout_out == to)) stable = 1'b0;
      end
      stray_valid = 1'b0;
      resp_ready = 1'b1;
      @(negedge clk);
      resp_ready = 1'b0;
      done_ok = !resp_valid_out && cell_ready_out && !busy_out;
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    checks++;
    if ({map_req_out, map_addr_out, resp_valid_out, resp_data_out, resp_oob_out,
         resp_timeout_out, busy_out, cell_ready_out} !== '0)
      begin errors++; $display("FAIL reset_outputs got req=%b addr=%0d rv=%b d=%0d rdy=%b want all 0",
        map_req_out, map_addr_out, resp_valid_out, resp_data_out, cell_ready_out); end
    rst_n = 1'b1;
    #1;
    checks++;
    if (cell_ready_out !== 1'b1 || busy_out !== 1'b0 || resp_valid_out !== 1'b0)
      begin errors++; $display("FAIL reset_release got rdy=%b busy=%b rv=%b want 1 0 0",
        cell_ready_out, busy_out, resp_valid_out); end
  endtask

  task automatic test_in_range();
    int lat, reqs; logic [DW-1:0] d; logic oob, to; logic [AW-1:0] a; bit st, ok;
    map_lat = 2;
    fetch(5'd3, 5'd2, 0, 1'b0, lat, d, oob, to, a, reqs, st, ok);
    checks++;
    if (a !== 10'd51) begin errors++; $display("FAIL in_range_addr got %0d want 51", a); end
    checks++;
    if (reqs !== 1) begin errors++; $display("FAIL in_range_reqs got %0d want 1", reqs); end
    checks++;
    if (lat !== 4) begin errors++; $display("FAIL in_range_latency got %0d want 4", lat); end
    checks++;
    if ({d, oob, to} !== {5'd7, 1'b0, 1'b0})
      begin errors++; $display("FAIL in_range_resp got d=%0d oob=%b to=%b want 7 0 0", d, oob, to); end
    checks++;
    if (!ok) begin errors++; $display("FAIL in_range_complete got %b want 1", ok); end
  endtask

  task automatic test_out_of_range();
    int lat, reqs; logic [DW-1:0] d; logic oob, to; logic [AW-1:0] a; bit st, ok;
    fetch(5'd24, 5'd0, 0, 1'b0, lat, d, oob, to, a, reqs, st, ok);
    checks++;
    if (reqs !== 0) begin errors++; $display("FAIL oob_reqs got %0d want 0", reqs); end
    checks++;
    if (lat !== 1) begin errors++; $display("FAIL oob_latency got %0d want 1", lat); end
    checks++;
    if ({d, oob, to} !== {5'd1, 1'b1, 1'b0})
      begin errors++; $display("FAIL oob_resp got d=%0d oob=%b to=%b want 1 1 0", d, oob, to); end
    fetch(5'd5, 5'd31, 2, 1'b0, lat, d, oob, to, a, reqs, st, ok);
    checks++;
    if ({lat, reqs, d, oob, to, st, ok} !== {32'd1, 32'd0, 5'd1, 1'b1, 1'b0, 1'b1, 1'b1})
      begin errors++; $display("FAIL oob_y_resp got lat=%0d reqs=%0d d=%0d oob=%b to=%b st=%b ok=%b want 1 0 1 1 0 1 1",
        lat, reqs, d, oob, to, st, ok); end
  endtask

  task automatic test_backpressure();
    int lat, reqs; logic [DW-1:0] d; logic oob, to; logic [AW-1:0] a; bit st, ok;
    map_lat = 2;
    fetch(5'd10, 5'd4, 5, 1'b0, lat, d, oob, to, a, reqs, st, ok);
    checks++;
    if (d !== mem[106] || a !== 10'd106)
      begin errors++; $display("FAIL bp_resp got d=%0d a=%0d want %0d 106", d, a, mem[106]); end
    checks++;
    if (!st) begin errors++; $display("FAIL bp_stable got %b want 1", st); end
    checks++;
    if (!ok) begin errors++; $display("FAIL bp_complete got %b want 1", ok); end
    fetch(5'd23, 5'd23, 0, 1'b0, lat, d, oob, to, a, reqs, st, ok);
    checks++;
    if (a !== 10'd575 || d !== mem[575] || lat !== 4)
      begin errors++; $display("FAIL corner_addr got a=%0d d=%0d lat=%0d want 575 %0d 4", a, d, lat, mem[575]); end
  endtask

  task automatic test_timeout();
    int lat, reqs, k; logic [DW-1:0] d; logic oob, to; logic [AW-1:0] a; bit st, ok;
    map_lat = 0;
    fetch(5'd1, 5'd1, 3, 1'b1, lat, d, oob, to, a, reqs, st, ok);
    checks++;
    if (lat !== TMO + 2) begin errors++; $display("FAIL timeout_latency got %0d want %0d", lat, TMO + 2); end
    checks++;
    if ({d, oob, to} !== {5'd1, 1'b0, 1'b1})
      begin errors++; $display("FAIL timeout_resp got d=%0d oob=%b to=%b want 1 0 1", d, oob, to); end
    checks++;
    if (!st || !ok) begin errors++; $display("FAIL timeout_stray_ignored got st=%b ok=%b want 1 1", st, ok); end
    map_lat = TMO;
    fetch(5'd2, 5'd2, 0, 1'b0, lat, d, oob, to, a, reqs, st, ok);
    checks++;
    if ({lat, d, to} !== {TMO + 2, mem[50], 1'b0})
      begin errors++; $display("FAIL last_cycle_valid got lat=%0d d=%0d to=%b want %0d %0d 0",
        lat, d, to, TMO + 2, mem[50]); end
    map_lat = TMO + 1;
    fetch(5'd4, 5'd5, 0, 1'b0, lat, d, oob, to, a, reqs, st, ok);
    checks++;
    if ({lat, d, to} !== {TMO + 2, 5'd1, 1'b1})
      begin errors++; $display("FAIL one_late got lat=%0d d=%0d to=%b want %0d 1 1", lat, d, to, TMO + 2); end
    k = 0;
    while (rsp_busy && k < 40) begin @(negedge clk); k++; end
    @(negedge clk);
    checks++;
    if (busy_out !== 1'b0 || resp_valid_out !== 1'b0 || rsp_busy)
      begin errors++; $display("FAIL late_valid_idle got busy=%b rv=%b want 0 0", busy_out, resp_valid_out); end
    map_lat = 1;
    fetch(5'd0, 5'd0, 0, 1'b0, lat, d, oob, to, a, reqs, st, ok);
    checks++;
    if ({lat, d, to} !== {32'd3, mem[0], 1'b0})
      begin errors++; $display("FAIL fast_map got lat=%0d d=%0d to=%b want 3 %0d 0", lat, d, to, mem[0]); end
  endtask

  task automatic test_reset_async();
    int k;
    map_lat = 2;
    cell_valid = 1'b1; cell_x = 5'd3; cell_y = 5'd2;
    @(negedge clk);
    cell_valid = 1'b0;
    k = 0;
    while (!resp_valid_out && k < 20) begin @(negedge clk); k++; end
    checks++;
    if (resp_valid_out !== 1'b1 || resp_data_out !== 5'd7)
      begin errors++; $display("FAIL async_pre got rv=%b d=%0d want 1 7", resp_valid_out, resp_data_out); end
    @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    checks++;
    if ({map_req_out, map_addr_out, resp_valid_out, resp_data_out, resp_oob_out,
         resp_timeout_out, busy_out, cell_ready_out} !== '0)
      begin errors++; $display("FAIL async_reset got addr=%0d rv=%b d=%0d busy=%b rdy=%b want all 0",
        map_addr_out, resp_valid_out, resp_data_out, busy_out, cell_ready_out); end
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    checks++;
    if (cell_ready_out !== 1'b1) begin errors++; $display("FAIL async_release got %b want 1", cell_ready_out); end
  endtask

  task automatic test_reset_mid_wait();
    int lat, reqs; logic [DW-1:0] d; logic oob, to; logic [AW-1:0] a; bit st, ok, seen;
    @(negedge clk);
    map_lat = 0;
    cell_valid = 1'b1; cell_x = 5'd7; cell_y = 5'd7;
    @(negedge clk);
    cell_valid = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if (busy_out !== 1'b1 || resp_valid_out !== 1'b0)
      begin errors++; $display("FAIL mid_wait_pre got busy=%b rv=%b want 1 0", busy_out, resp_valid_out); end
    #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if (busy_out !== 1'b0 || map_addr_out !== '0)
      begin errors++; $display("FAIL mid_wait_reset got busy=%b addr=%0d want 0 0", busy_out, map_addr_out); end
    @(negedge clk);
    rst_n = 1'b1;
    seen = 1'b0;
    repeat (20) begin
      @(negedge clk);
      if (resp_valid_out || busy_out) seen = 1'b1;
    end
    checks++;
    if (seen) begin errors++; $display("FAIL mid_wait_no_resp got %b want 0", seen); end
    map_lat = 2;
    fetch(5'd0, 5'd1, 0, 1'b0, lat, d, oob, to, a, reqs, st, ok);
    checks++;
    if ({a, d, oob, to, lat} !== {10'd24, mem[24], 1'b0, 1'b0, 32'd4})
      begin errors++; $display("FAIL post_reset_fetch got a=%0d d=%0d oob=%b to=%b lat=%0d want 24 %0d 0 0 4",
        a, d, oob, to, lat, mem[24]); end
  endtask

  task automatic test_random();
    int lat, reqs, lt, hold, ia, e_lat, e_reqs; logic [DW-1:0] d, e_d; logic oob, to, e_oob, e_to;
    logic [AW-1:0] a; bit st, ok; logic [XW-1:0] x, y;
    for (int it = 0; it < 40; it++) begin
      x = ($urandom_range(0, 3) == 0) ? XW'($urandom_range(0, 31)) : XW'($urandom_range(0, N - 1));
      y = ($urandom_range(0, 3) == 0) ? XW'($urandom_range(0, 31)) : XW'($urandom_range(0, N - 1));
      case ($urandom_range(0, 9))
        0:       lt = 0;
        1:       lt = $urandom_range(TMO + 1, TMO + 4);
        default: lt = $urandom_range(1, TMO);
      endcase
      hold = $urandom_range(0, 3);
      map_lat = lt;
      ia = int'(y) * N + int'(x);
      e_oob  = (int'(x) >= N) || (int'(y) >= N);
      e_to   = !e_oob && (lt == 0 || lt > TMO);
      e_d    = (e_oob || e_to) ? DW'(OOBV) : mem[ia];
      e_lat  = e_oob ? 1 : (e_to ? TMO + 2 : lt + 2);
      e_reqs = e_oob ? 0 : 1;
      fetch(x, y, hold, 1'b0, lat, d, oob, to, a, reqs, st, ok);
      checks++;
      if ({d, oob, to} !== {e_d, e_oob, e_to})
        begin errors++; $display("FAIL rnd_resp[%0d] x=%0d y=%0d lat=%0d got d=%0d oob=%b to=%b want %0d %b %b",
          it, x, y, lt, d, oob, to, e_d, e_oob, e_to); end
      checks++;
      if (lat !== e_lat || reqs !== e_reqs)
        begin errors++; $display("FAIL rnd_timing[%0d] got lat=%0d reqs=%0d want %0d %0d", it, lat, reqs, e_lat, e_reqs); end
      if (!e_oob) begin
        checks++;
        if (a !== AW'(ia)) begin errors++; $display("FAIL rnd_addr[%0d] got %0d want %0d", it, a, ia); end
      end
      checks++;
      if (!st || !ok) begin errors++; $display("FAIL rnd_handshake[%0d] got st=%b ok=%b want 1 1", it, st, ok); end
    end
  endtask

  task automatic test_req_pulse();
    checks++;
    if (gap_viol !== 0) begin errors++; $display("FAIL req_pulse_gap got %0d want 0", gap_viol); end
  endtask

  initial begin
    for (int i = 0; i < N * N; i++) mem[i] = DW'($urandom);
    mem[51] = 5'd7;
    cell_valid = 1'b0; cell_x = '0; cell_y = '0; resp_ready = 1'b0;
    stray_valid = 1'b0; stray_data = '0;
    test_reset();
    test_in_range();
    test_out_of_range();
    test_backpressure();
    test_timeout();
    test_reset_async();
    test_reset_mid_wait();
    test_random();
    test_req_pulse();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #400000;
    $display("FAIL watchdog_expired got running want finished");
    $fatal(1, "watchdog");
  end

endmodule
